sram2axi4lite: RTL and testbench
================================

# sram2axi4lite

Bridge from the internal SRAM-style request bus to an AXI4-Lite master port: the opposite end of the AXI4-Lite-to-SRAM slave bridge. A core or DMA engine issues simple SRAM-bus requests. This block converts each one into a single AXI4-Lite write or read transaction and returns read data on the SRAM bus. Only one transaction is outstanding at a time. It sits between SRAM-bus initiators and the AXI4-Lite interconnect.

## Interface
- DW, 32, data width in bits; multiple of 8.
- AW, 32, address width in bits.

- clk  input  1  clock.
- rst_b  input  1  reset; asynchronous, active-low.
- sram_req  input  1  request valid.
- sram_write  input  1  1 = write, 0 = read; sampled with sram_req.
- sram_wstrb  input  DW/8  write byte strobes.
- sram_addr  input  AW  byte address.
- sram_wdata  input  DW  write data.
- sram_ready  output  1  bridge can accept a request this cycle.
- sram_rvalid  output  1  one-cycle pulse; read data valid.
- sram_rdata  output  DW  read data.
- axi_awvalid / axi_awready / axi_awaddr[AW] / axi_awprot[3]  AXI write address channel (master side).
- axi_wvalid / axi_wready / axi_wdata[DW] / axi_wstrb[DW/8]  AXI write data channel.
- axi_bvalid / axi_bresp[2] / axi_bready  AXI write response channel.
- axi_arvalid / axi_arready / axi_araddr[AW] / axi_arprot[3]  AXI read address channel.
- axi_rvalid / axi_rdata[DW] / axi_rresp[2] / axi_rready  AXI read data channel.
- sram_err  output  1  present only with SRAM2AXI4LITE_ERR_EN; see Configuration.

## Operation
- An SRAM request is accepted when sram_req && sram_ready. The SRAM bus has no read backpressure and no write response.
- sram_ready = (state == IDLE), purely from registered state.
- On acceptance, the bridge registers the following into holding registers: addr, wdata, wstrb, and direction.
- axi_awprot and axi_arprot are constant 3'b000.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
  - IDLE -> WR_REQ on an accepted write. Set axi_awvalid=1 and axi_wvalid=1, plus internal flags aw_done=0 and w_done=0.
  - IDLE -> RD_REQ on an accepted read. Set axi_arvalid=1.
  - WR_REQ: AW and W complete independently.
    - axi_awvalid drops the cycle after the awvalid&&awready handshake, and aw_done sets.
    - W behaves the same way with w_done.
    - Both handshakes may occur in the same cycle or in either order.
    - Go to WR_RESP once both are complete, counting a handshake that completes in the current cycle.
  - WR_RESP: axi_bready=1. On bvalid, go to IDLE. bresp is ignored unless ERR_EN is defined.
  - RD_REQ: axi_arvalid held until the arready handshake, then go to RD_RESP.
  - RD_RESP: axi_rready=1. On rvalid, capture rdata into sram_rdata, pulse sram_rvalid for the next cycle, and go to IDLE.
- axi_bready and axi_rready are 0 in all other states. Unexpected bvalid or rvalid is not acknowledged.
- Valid signals, once asserted, are held stable, together with their payload, until the handshake completes (AXI rule).
- sram_rdata holds its last captured value between reads.

## Timing
- Reset values:
  - state = IDLE, so sram_ready = 1.
  - All axi_*valid = 0; axi_bready = 0; axi_rready = 0.
  - sram_rvalid = 0; sram_rdata = 0; axi address, data and strobe outputs = 0; sram_err = 0.
- Write, zero-wait slave:
  - Accept at cycle 0.
  - awvalid/wvalid high at cycle 1; handshake at cycle 1.
  - bready at cycle 2; bvalid at cycle 2.
  - sram_ready at cycle 3.
- Read, zero-wait slave:
  - Accept at cycle 0.
  - arvalid at cycle 1.
  - rready at cycle 2; rvalid at cycle 2.
  - sram_rvalid and sram_rdata at cycle 3.
  - sram_ready also returns at cycle 3, so the next request is accepted in cycle 3.
- Slave wait states add cycles 1:1. There is no timeout.
- sram_req while sram_ready=0 is not accepted. The initiator must hold the request.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously and the transaction is abandoned. The interconnect must be reset alongside.

## Configuration
- Macro: SRAM2AXI4LITE_ERR_EN.
- Defined:
  - Port sram_err exists.
  - It pulses for 1 cycle in the cycle after a B handshake with bresp != 2'b00.
  - For reads, it pulses coincident with sram_rvalid when rresp != 2'b00.
  - Read data is still returned.
- Undefined: port sram_err is absent and bresp/rresp are ignored.

## Test plan
- Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, zero-wait slave:
  - awaddr=0x10 and wdata=0xDEADBEEF at cycle 1.
  - sram_ready=0 for cycles 1-2 and back to 1 at cycle 3.
- Write with AW accepted 3 cycles before W:
  - awvalid drops after its handshake while wvalid stays high.
  - bready asserts only after both handshakes.
  - Exactly one B is consumed.
- Read addr=0x20, slave returns 0x12345678 after arready delayed 2 cycles and rvalid delayed 4:
  - sram_rvalid is a single pulse with sram_rdata=0x12345678.
  - arvalid is stable until the handshake.
- Back-to-back read then write with sram_req held high:
  - The second request is accepted only in the cycle sram_ready=1.
  - AXI ordering is AR, R, AW/W, B.
- With ERR_EN, slave returns bresp=2'b10, then rresp=2'b11:
  - sram_err pulses once per transaction.
  - Without ERR_EN, the same stimulus completes normally.
- rst_b asserted while in WR_REQ:
  - awvalid, wvalid, and bready go to 0 immediately.
  - After release, sram_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/sram2axi4lite.sv
// SRAM-style request bus to AXI4-Lite master bridge with one transaction outstanding.
// Optional feature macro SRAM2AXI4LITE_ERR_EN adds sram_err, which reports a non-OKAY bresp or rresp.
module sram2axi4lite #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            sram_req,
  input  logic            sram_write,
  input  logic [DW/8-1:0] sram_wstrb,
  input  logic [AW-1:0]   sram_addr,
  input  logic [DW-1:0]   sram_wdata,
  output logic            sram_ready,
  output logic            sram_rvalid,
  output logic [DW-1:0]   sram_rdata,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [AW-1:0]   axi_awaddr,
  output logic [2:0]      axi_awprot,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [DW-1:0]   axi_wdata,
  output logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_bvalid,
  input  logic [1:0]      axi_bresp,
  output logic            axi_bready,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [AW-1:0]   axi_araddr,
  output logic [2:0]      axi_arprot,
  input  logic            axi_rvalid,
  input  logic [DW-1:0]   axi_rdata,
  input  logic [1:0]      axi_rresp,
  output logic            axi_rready
`ifdef SRAM2AXI4LITE_ERR_EN
  ,
  output logic            sram_err
`endif
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            accept, aw_hs, w_hs;

  // All handshake outputs decode registered state only, so they drop asynchronously on reset.
  assign sram_ready  = (state_q == IDLE);
  assign accept      = sram_req && sram_ready;
  assign axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi_bready  = (state_q == WR_RESP);
  assign axi_arvalid = (state_q == RD_REQ);
  assign axi_rready  = (state_q == RD_RESP);
  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_awprot  = 3'b000;
  assign axi_arprot  = 3'b000;
  assign sram_rvalid = rvalid_q;
  assign sram_rdata  = rdata_q;
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The transfer direction is carried by the state encoding itself.
        if (accept) begin
          addr_d    = sram_addr;
          wdata_d   = sram_wdata;
          wstrb_d   = sram_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sram_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (axi_bvalid) state_d = IDLE;
      RD_REQ:  if (axi_arready) state_d = RD_RESP;
      RD_RESP: begin
        if (axi_rvalid) begin
          rdata_d  = axi_rdata;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef SRAM2AXI4LITE_ERR_EN
  logic err_q, err_d;

  // A write error follows the B handshake; a read error lines up with sram_rvalid.
  always_comb begin
    err_d = ((state_q == WR_RESP) && axi_bvalid && (axi_bresp != 2'b00)) ||
            ((state_q == RD_RESP) && axi_rvalid && (axi_rresp != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign sram_err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{axi_bresp, axi_rresp};
`endif

endmodule

// File: tb/tb_sram2axi4lite.sv
// Bench for sram2axi4lite: a randomized-latency AXI4-Lite slave with a byte-strobed memory,
// plus a word-level reference memory and latency arithmetic used to predict every result.
module tb_sram2axi4lite;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        sram_req = 1'b0, sram_write = 1'b0;
  logic [3:0]  sram_wstrb = '0;
  logic [31:0] sram_addr = '0, sram_wdata = '0;
  logic        sram_ready, sram_rvalid;
  logic [31:0] sram_rdata;
  logic        axi_awvalid, axi_awready = 1'b0;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot, axi_arprot;
  logic        axi_wvalid, axi_wready = 1'b0;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid = 1'b0, axi_bready;
  logic [1:0]  axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic        axi_arvalid, axi_arready = 1'b0;
  logic [31:0] axi_araddr;
  logic        axi_rvalid = 1'b0, axi_rready;
  logic [31:0] axi_rdata = '0;
`ifdef SRAM2AXI4LITE_ERR_EN
  logic        sram_err;
`endif

  always #5 clk = ~clk;

  sram2axi4lite dut (
    .clk(clk), .rst_b(rst_b),
    .sram_req(sram_req), .sram_write(sram_write), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ready(sram_ready),
    .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
    .axi_bresp(axi_bresp), .axi_bready(axi_bready), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rready(axi_rready)
`ifdef SRAM2AXI4LITE_ERR_EN
    , .sram_err(sram_err)
`endif
  );

  // Slave configuration: ready delays per channel, response delays, response codes.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit b_hs = 0, r_hs = 0;
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] smem[int];
  logic [31:0] ref_mem[int];
  int log_q[$];
  int viol = 0, err_pulses = 0, err_rv = 0;
  int n_chk = 0, n_pass = 0;

  // Monitor: handshakes, slave memory updates, AXI stability rule.
  initial begin
    logic p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr, a, old;
    logic [3:0] p_wstrb;
    logic [35:0] wd;
    p_aw = 0; p_w = 0; p_ar = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw && (!axi_awvalid || axi_awaddr !== p_awaddr)) viol++;
        if (p_w && (!axi_wvalid || axi_wdata !== p_wdata || axi_wstrb !== p_wstrb)) viol++;
        if (p_ar && (!axi_arvalid || axi_araddr !== p_araddr)) viol++;
        p_aw = axi_awvalid && !axi_awready; p_awaddr = axi_awaddr;
        p_w  = axi_wvalid && !axi_wready;   p_wdata = axi_wdata; p_wstrb = axi_wstrb;
        p_ar = axi_arvalid && !axi_arready; p_araddr = axi_araddr;
        if (axi_awvalid && axi_awready) begin aw_q.push_back(axi_awaddr); aw_cnt++; log_q.push_back(3); end
        if (axi_wvalid && axi_wready) begin w_q.push_back({axi_wstrb, axi_wdata}); w_cnt++; log_q.push_back(4); end
        while (aw_q.size() > 0 && w_q.size() > 0) begin
          a = aw_q.pop_front();
          wd = w_q.pop_front();
          old = smem.exists(int'(a >> 2)) ? smem[int'(a >> 2)] : 32'h0;
          for (int b = 0; b < 4; b++) if (wd[32 + b]) old[8*b +: 8] = wd[8*b +: 8];
          smem[int'(a >> 2)] = old;
        end
        if (axi_bvalid && axi_bready) begin b_cnt++; b_hs = 1; log_q.push_back(5); end
        if (axi_arvalid && axi_arready) begin ar_q.push_back(axi_araddr); ar_cnt++; log_q.push_back(1); end
        if (axi_rvalid && axi_rready) begin r_cnt++; r_hs = 1; log_q.push_back(2); end
`ifdef SRAM2AXI4LITE_ERR_EN
        if (sram_err) err_pulses++;
        if (sram_err && sram_rvalid) err_rv++;
`endif
      end
    end
  end

  // Slave driver: ready after a configured wait, responses after a configured wait.
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk); #1;
      if (axi_awvalid) begin if (aw_wait > 0) begin axi_awready = 0; aw_wait--; end else axi_awready = 1; end
      else begin aw_wait = aw_dly; axi_awready = (aw_dly == 0); end
      if (axi_wvalid) begin if (w_wait > 0) begin axi_wready = 0; w_wait--; end else axi_wready = 1; end
      else begin w_wait = w_dly; axi_wready = (w_dly == 0); end
      if (axi_arvalid) begin if (ar_wait > 0) begin axi_arready = 0; ar_wait--; end else axi_arready = 1; end
      else begin ar_wait = ar_dly; axi_arready = (ar_dly == 0); end
      if (b_hs) begin axi_bvalid = 0; b_hs = 0; end
      if (!axi_bvalid) begin
        if (((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_cnt) begin
          if (b_wait > 0) b_wait--;
          else begin axi_bvalid = 1; axi_bresp = b_resp_cfg; end
        end else b_wait = b_dly;
      end
      if (r_hs) begin axi_rvalid = 0; r_hs = 0; end
      if (!axi_rvalid) begin
        if (ar_q.size() > 0) begin
          if (r_wait > 0) r_wait--;
          else begin
            a = ar_q.pop_front();
            axi_rvalid = 1; axi_rresp = r_resp_cfg;
            axi_rdata = smem.exists(int'(a >> 2)) ? smem[int'(a >> 2)] : 32'h0;
          end
        end else r_wait = r_dly;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'h0;
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ref_mem[int'(a >> 2)] = (ref_rd(a) & ~m) | (d & m);
  endfunction

  // One SRAM transaction: hold the request until accepted, then wait for sram_ready.
  task automatic sram_op(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output bit ok, output int lat, output logic [31:0] rd, output int npulse);
    bit acc;
    acc = 0; ok = 0; lat = 0; rd = '0; npulse = 0;
    @(posedge clk); #1;
    sram_req = 1; sram_write = wr; sram_addr = a; sram_wdata = d; sram_wstrb = s;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); #1;
      if (sram_ready) acc = 1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    sram_req = 0;
    if (acc) begin
      for (int c = 1; c < 200; c++) begin
        @(negedge clk); #1;
        if (sram_rvalid) begin npulse++; rd = sram_rdata; end
        if (sram_ready) begin lat = c; ok = 1; break; end
      end
    end
  endtask

  task automatic test_reset;
    #12;
    n_chk++; if (sram_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", sram_ready); else n_pass++;
    n_chk++; if ({axi_awvalid, axi_wvalid, axi_arvalid} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {axi_awvalid, axi_wvalid, axi_arvalid}); else n_pass++;
    n_chk++; if ({axi_bready, axi_rready, sram_rvalid} !== 3'b000) $display("FAIL rst_readys: got %b want 000", {axi_bready, axi_rready, sram_rvalid}); else n_pass++;
    n_chk++; if (sram_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", sram_rdata); else n_pass++;
    n_chk++; if ({axi_awaddr, axi_araddr, axi_wdata, axi_wstrb} !== 100'h0) $display("FAIL rst_payload: got %h %h %h %h want 0", axi_awaddr, axi_araddr, axi_wdata, axi_wstrb); else n_pass++;
    n_chk++; if ({axi_awprot, axi_arprot} !== 6'b0) $display("FAIL rst_prot: got %b want 000000", {axi_awprot, axi_arprot}); else n_pass++;
`ifdef SRAM2AXI4LITE_ERR_EN
    n_chk++; if (sram_err !== 1'b0) $display("FAIL rst_err: got %b want 0", sram_err); else n_pass++;
`endif
    @(negedge clk); #2;
    rst_b = 1;
  endtask

  task automatic test_write_basic;
    set_dly(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    sram_req = 1; sram_write = 1; sram_addr = 32'h10; sram_wdata = 32'hDEADBEEF; sram_wstrb = 4'hF;
    @(negedge clk); #1;
    n_chk++; if (sram_ready !== 1'b1) $display("FAIL wr_c0_ready: got %b want 1", sram_ready); else n_pass++;
    @(posedge clk); #1;
    sram_req = 0;
    @(negedge clk); #1;
    n_chk++; if ({axi_awvalid, axi_wvalid, sram_ready} !== 3'b110) $display("FAIL wr_c1_ctl: got %b want 110", {axi_awvalid, axi_wvalid, sram_ready}); else n_pass++;
    n_chk++; if (axi_awaddr !== 32'h10 || axi_wdata !== 32'hDEADBEEF || axi_wstrb !== 4'hF) $display("FAIL wr_c1_payload: got %h %h %h want 00000010 deadbeef f", axi_awaddr, axi_wdata, axi_wstrb); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({axi_bready, axi_bvalid, sram_ready} !== 3'b110) $display("FAIL wr_c2_ctl: got %b want 110", {axi_bready, axi_bvalid, sram_ready}); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({sram_ready, axi_bready, axi_awvalid} !== 3'b100) $display("FAIL wr_c3_ctl: got %b want 100", {sram_ready, axi_bready, axi_awvalid}); else n_pass++;
    ref_wr(32'h10, 32'hDEADBEEF, 4'hF);
    n_chk++; if (smem[4] !== ref_rd(32'h10)) $display("FAIL wr_mem: got %h want %h", smem[4], ref_rd(32'h10)); else n_pass++;
  endtask

  task automatic test_aw_before_w;
    int w0, b0, aw0, early, lat;
    bit w_seen;
    set_dly(0, 3, 0, 0, 0);
    w0 = w_cnt; b0 = b_cnt; aw0 = aw_cnt; early = 0; lat = 0; w_seen = 0;
    @(posedge clk); #1;
    sram_req = 1; sram_write = 1; sram_addr = 32'h24; sram_wdata = 32'hA5A5_0F0F; sram_wstrb = 4'h5;
    @(negedge clk); #1;
    @(posedge clk); #1;
    sram_req = 0;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk); #1;
      if (c == 2) begin
        n_chk++; if ({axi_awvalid, axi_wvalid} !== 2'b01) $display("FAIL awfirst_c2: got %b want 01", {axi_awvalid, axi_wvalid}); else n_pass++;
      end
      if (axi_bready && !w_seen) early++;
      w_seen = (w_cnt > w0);
      if (sram_ready) begin lat = c; break; end
    end
    repeat (3) @(negedge clk);
    #1;
    ref_wr(32'h24, 32'hA5A5_0F0F, 4'h5);
    n_chk++; if (early !== 0) $display("FAIL awfirst_early_bready: got %0d want 0", early); else n_pass++;
    n_chk++; if (lat !== 6) $display("FAIL awfirst_latency: got %0d want 6", lat); else n_pass++;
    n_chk++; if (b_cnt - b0 !== 1 || aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1) $display("FAIL awfirst_counts: got b=%0d aw=%0d w=%0d want 1 1 1", b_cnt - b0, aw_cnt - aw0, w_cnt - w0); else n_pass++;
    n_chk++; if (smem[9] !== ref_rd(32'h24)) $display("FAIL awfirst_mem: got %h want %h", smem[9], ref_rd(32'h24)); else n_pass++;
  endtask

  task automatic test_read_delayed;
    bit ok; int lat, np, v0; logic [31:0] rd;
    smem[8] = 32'h12345678; ref_mem[8] = 32'h12345678;
    set_dly(0, 0, 0, 2, 4);
    v0 = viol;
    sram_op(0, 32'h20, 32'h0, 4'h0, ok, lat, rd, np);
    n_chk++; if (!ok) $display("FAIL rd_timeout: got no completion want completion"); else n_pass++;
    n_chk++; if (np !== 1) $display("FAIL rd_pulses: got %0d want 1", np); else n_pass++;
    n_chk++; if (rd !== 32'h12345678) $display("FAIL rd_data: got %h want 12345678", rd); else n_pass++;
    n_chk++; if (lat !== 9) $display("FAIL rd_latency: got %0d want 9", lat); else n_pass++;
    n_chk++; if (viol !== v0) $display("FAIL rd_stability: got %0d violations want 0", viol - v0); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (sram_rvalid !== 1'b0) $display("FAIL rd_pulse_width: got %b want 0", sram_rvalid); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (sram_rdata !== 32'h12345678) $display("FAIL rd_hold: got %h want 12345678", sram_rdata); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int acc_c, v, fin;
    bit rv_at_acc; logic [31:0] rd_at_acc;
    set_dly(0, 0, 0, 0, 0);
    smem[16] = 32'hCAFE_F00D; ref_mem[16] = 32'hCAFE_F00D;
    log_q.delete();
    acc_c = 0; fin = 0; rv_at_acc = 0; rd_at_acc = '0;
    @(posedge clk); #1;
    sram_req = 1; sram_write = 0; sram_addr = 32'h40;
    @(negedge clk); #1;
    @(posedge clk); #1;
    sram_write = 1; sram_addr = 32'h44; sram_wdata = 32'h0BAD_BEEF; sram_wstrb = 4'hF;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk); #1;
      if (sram_ready) begin acc_c = c; rv_at_acc = sram_rvalid; rd_at_acc = sram_rdata; break; end
    end
    @(posedge clk); #1;
    sram_req = 0;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk); #1;
      if (sram_ready) begin fin = c; break; end
    end
    ref_wr(32'h44, 32'h0BAD_BEEF, 4'hF);
    v = 0;
    foreach (log_q[i]) v = v * 10 + log_q[i];
    n_chk++; if (acc_c !== 3) $display("FAIL b2b_accept_cycle: got %0d want 3", acc_c); else n_pass++;
    n_chk++; if (rv_at_acc !== 1'b1 || rd_at_acc !== 32'hCAFE_F00D) $display("FAIL b2b_rdata: got %b %h want 1 cafef00d", rv_at_acc, rd_at_acc); else n_pass++;
    n_chk++; if (v !== 12345) $display("FAIL b2b_order: got %0d want 12345", v); else n_pass++;
    n_chk++; if (fin !== 3 || smem[17] !== ref_rd(32'h44)) $display("FAIL b2b_write: got lat=%0d mem=%h want 3 %h", fin, smem[17], ref_rd(32'h44)); else n_pass++;
  endtask

  task automatic test_err;
    bit ok; int lat, np, e0, er0; logic [31:0] rd;
    set_dly(0, 0, 0, 0, 0);
    e0 = err_pulses; er0 = err_rv;
    b_resp_cfg = 2'b10;
    sram_op(1, 32'h50, 32'h1357_9BDF, 4'hF, ok, lat, rd, np);
    ref_wr(32'h50, 32'h1357_9BDF, 4'hF);
    n_chk++; if (!ok || lat !== 3) $display("FAIL err_wr_complete: got ok=%0d lat=%0d want 1 3", ok, lat); else n_pass++;
`ifdef SRAM2AXI4LITE_ERR_EN
    @(negedge clk); #1;
    n_chk++; if (err_pulses - e0 !== 1) $display("FAIL err_wr_pulses: got %0d want 1", err_pulses - e0); else n_pass++;
`endif
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
    sram_op(0, 32'h50, 32'h0, 4'h0, ok, lat, rd, np);
    n_chk++; if (!ok || rd !== ref_rd(32'h50) || np !== 1) $display("FAIL err_rd_data: got ok=%0d %h np=%0d want 1 %h 1", ok, rd, np, ref_rd(32'h50)); else n_pass++;
`ifdef SRAM2AXI4LITE_ERR_EN
    @(negedge clk); #1;
    n_chk++; if (err_pulses - e0 !== 2 || err_rv - er0 !== 1) $display("FAIL err_rd_pulses: got %0d %0d want 2 1", err_pulses - e0, err_rv - er0); else n_pass++;
`endif
    r_resp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid;
    bit ok; int lat, np; logic [31:0] rd;
    set_dly(5, 5, 0, 0, 0);
    @(posedge clk); #1;
    sram_req = 1; sram_write = 1; sram_addr = 32'h30; sram_wdata = 32'h7777_7777; sram_wstrb = 4'hF;
    @(negedge clk); #1;
    @(posedge clk); #1;
    sram_req = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_chk++; if ({axi_awvalid, axi_wvalid} !== 2'b11) $display("FAIL mrst_pre: got %b want 11", {axi_awvalid, axi_wvalid}); else n_pass++;
    #1;
    rst_b = 0;
    #1;
    n_chk++; if ({axi_awvalid, axi_wvalid, axi_bready, sram_ready} !== 4'b0001) $display("FAIL mrst_outputs: got %b want 0001", {axi_awvalid, axi_wvalid, axi_bready, sram_ready}); else n_pass++;
    aw_q.delete(); w_q.delete(); ar_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    b_hs = 0; r_hs = 0; axi_bvalid = 0; axi_rvalid = 0;
    set_dly(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_b = 1;
    sram_op(0, 32'h10, 32'h0, 4'h0, ok, lat, rd, np);
    n_chk++; if (!ok || lat !== 3 || rd !== ref_rd(32'h10)) $display("FAIL mrst_read: got ok=%0d lat=%0d %h want 1 3 %h", ok, lat, rd, ref_rd(32'h10)); else n_pass++;
    n_chk++; if (smem.exists(12)) $display("FAIL mrst_abandon: got word written %h want absent", smem[12]); else n_pass++;
  endtask

  task automatic test_random;
    bit ok, wr; int lat, np, w, exp_lat;
    logic [31:0] a, d, rd; logic [3:0] s;
    for (int i = 0; i < 40; i++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 7);
      a = 32'h100 + 32'(w * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      sram_op(wr, a, d, s, ok, lat, rd, np);
      if (wr) begin
        ref_wr(a, d, s);
        exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        n_chk++; if (!ok || lat !== exp_lat) $display("FAIL rnd_wr_lat[%0d]: got ok=%0d lat=%0d want %0d", i, ok, lat, exp_lat); else n_pass++;
        n_chk++; if (smem[int'(a >> 2)] !== ref_rd(a)) $display("FAIL rnd_wr_mem[%0d]: got %h want %h", i, smem[int'(a >> 2)], ref_rd(a)); else n_pass++;
      end else begin
        exp_lat = 3 + ar_dly + r_dly;
        n_chk++; if (!ok || lat !== exp_lat || np !== 1) $display("FAIL rnd_rd_lat[%0d]: got ok=%0d lat=%0d np=%0d want %0d 1", i, ok, lat, np, exp_lat); else n_pass++;
        n_chk++; if (rd !== ref_rd(a)) $display("FAIL rnd_rd_data[%0d]: got %h want %h", i, rd, ref_rd(a)); else n_pass++;
      end
    end
    n_chk++; if (viol !== 0) $display("FAIL rnd_stability: got %0d violations want 0", viol); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_aw_before_w;
    test_read_delayed;
    test_back_to_back;
    test_err;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
